rr_arb4_8b: RTL and testbench



---
 rtl/rr_arb4_8b_pkg.sv | 6 +
 rtl/rr_arb4_8b_mux41_8b.sv | 14 +
 rtl/rr_arb4_8b.sv | 74 +++++++
 tb/tb_rr_arb4_8b.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb4_8b_pkg.sv
// rr_arb4_8b_pkg: shared arbiter states and fixed sizes.
package rr_arb4_8b_pkg;
    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
    localparam int N = 4;
    localparam int W = 8;
endpackage

// File: rtl/rr_arb4_8b_mux41_8b.sv
// mux41_8b: 8-bit 4:1 select with enable; output is zero when disabled.
module mux41_8b
    import rr_arb4_8b_pkg::*;
(
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   a,
    input  logic         en,
    output logic [W-1:0] y
);
    always_comb y = !en ? '0 : a == 2'd0 ? d0 : a == 2'd1 ? d1 : a == 2'd2 ? d2 : d3;
endmodule

// File: rtl/rr_arb4_8b.sv
// rr_arb4_8b: 4-way round-robin packet arbiter onto one registered 8-bit stream.
module rr_arb4_8b
    import rr_arb4_8b_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_valid,
    input  logic [N-1:0] in_last,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [N-1:0] in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   out_src,
    input  logic         out_ready,
    output logic         busy
);
    state_t state;
    logic [1:0] ptr, owner, sel;
    logic load, accept;
    logic [W-1:0] mux_y;

    // First valid requester at or after p, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [N-1:0] v, input logic [1:0] p);
        rr_pick = p;
        for (int k = N - 1; k >= 0; k--)
            if (v[p + 2'(k)]) rr_pick = p + 2'(k);
    endfunction

    assign load = ~out_valid | out_ready;
    assign sel = state == LOCK ? owner : rr_pick(in_valid, ptr);
    assign in_ready = (state == LOCK || |in_valid) && load ? 4'b0001 << sel : 4'b0000;
    assign accept = in_valid[sel] & in_ready[sel];
    assign busy = state == LOCK || out_valid;

    mux41_8b u_mux (
        .d0(in_data0),
        .d1(in_data1),
        .d2(in_data2),
        .d3(in_data3),
        .a(sel),
        .en(1'b1),
        .y(mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr <= 2'd0;
            owner <= 2'd0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_src <= 2'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data <= mux_y;
            out_src <= sel;
            out_last <= in_last[sel];
            if (in_last[sel]) begin
                ptr <= sel + 2'd1;
                state <= ARB;
            end else begin
                owner <= sel;
                state <= LOCK;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arb4_8b.sv
// tb_rr_arb4_8b: directed and random checks of rr_arb4_8b against a packet-level model.
module tb_rr_arb4_8b;
    logic clk = 0, rst_n = 0, out_ready = 0;
    logic [3:0] in_valid = 0, in_last = 0, in_ready;
    logic [7:0] d[4];
    logic out_valid, out_last, busy;
    logic [7:0] out_data;
    logic [1:0] out_src;
    int n_chk = 0, n_fail = 0;

    // model: ptr as int, owner = -1 when nobody holds the output
    int m_ptr, m_owner;
    logic m_ov, m_ol;
    logic [7:0] m_od;
    logic [1:0] m_os;

    rr_arb4_8b dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_data0(d[0]), .in_data1(d[1]), .in_data2(d[2]), .in_data3(d[3]),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_src(out_src), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < 4; k++) if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g = m_grant();
        if (g < 0 || !(!m_ov || out_ready)) return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic logic [12:0] m_out();
        return {m_ov, m_od, m_ol, m_os, (m_owner >= 0) || m_ov};
    endfunction

    wire [12:0] dut_out = {out_valid, out_data, out_last, out_src, busy};

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_ov = 0; m_ol = 0; m_od = 0; m_os = 0;
    endtask

    task automatic tick();
        logic [3:0] r;
        int g;
        r = m_ready();
        g = m_grant();
        @(posedge clk);
        if (r != 0 && in_valid[g]) begin
            m_ov = 1; m_od = d[g]; m_os = 2'(g); m_ol = in_last[g];
            if (in_last[g]) begin m_ptr = (g + 1) % 4; m_owner = -1; end
            else m_owner = g;
        end else if (out_ready) m_ov = 0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 0; in_last = 0; out_ready = 0;
        for (int i = 0; i < 4; i++) d[i] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (dut_out !== 13'h0) begin n_fail++; $display("FAIL reset_out: got %h want %h", dut_out, 13'h0); end
        n_chk++;
        if (in_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0100; in_last = 4'b0100; d[2] = 8'hA5; out_ready = 1;
        #1;
        n_chk++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", in_ready); end
        tick();
        n_chk++;
        if (dut_out !== {1'b1, 8'hA5, 1'b1, 2'd2, 1'b1}) begin n_fail++; $display("FAIL single_out: got %h want %h", dut_out, {1'b1, 8'hA5, 1'b1, 2'd2, 1'b1}); end
        // ptr is now 3, so requester 3 beats requester 0
        @(negedge clk);
        in_valid = 4'b1001; in_last = 4'b1001;
        #1;
        n_chk++;
        if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3: got %b want 1000", in_ready); end
    endtask

    task automatic test_fairness();
        do_reset();
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1;
        for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== 8'h10 + 8'(c % 4)) begin
                n_fail++; $display("FAIL fair_grant%0d: got v=%b src=%0d data=%h want v=1 src=%0d", c, out_valid, out_src, out_data, c % 4);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] beats[3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        out_ready = 1; in_valid = 4'b0010; d[0] = 8'hEE;
        for (int b = 0; b < 3; b++) begin
            d[1] = beats[b]; in_last = b == 2 ? 4'b0011 : 4'b0001;
            tick();
            n_chk++;
            if (out_src !== 2'd1 || out_data !== beats[b] || out_last !== (b == 2)) begin
                n_fail++; $display("FAIL lock_beat%0d: got src=%0d data=%h last=%b want src=1 data=%h", b, out_src, out_data, out_last, beats[b]);
            end
            @(negedge clk);
            in_valid = 4'b0011;
        end
        in_valid = 4'b0001; in_last = 4'b0001;
        tick();
        n_chk++;
        if (out_src !== 2'd0 || out_data !== 8'hEE) begin n_fail++; $display("FAIL lock_next: got src=%0d data=%h want src=0 data=ee", out_src, out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1; in_valid = 4'b0001; in_last = 4'b0001; d[0] = 8'h5A;
        tick();
        @(negedge clk);
        out_ready = 0; d[0] = 8'h6B;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_chk++;
            if (in_ready !== 4'b0 || out_data !== 8'h5A || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d: got ready=%b data=%h v=%b want ready=0000 data=5a v=1", c, in_ready, out_data, out_valid);
            end
            tick();
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        n_chk++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", in_ready); end
        tick();
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 8'h6B) begin n_fail++; $display("FAIL bp_no_bubble: got v=%b data=%h want v=1 data=6b", out_valid, out_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1; in_valid = 4'b0100; in_last = 4'hF;
        tick();
        @(negedge clk);
        in_valid = 4'b1001; d[3] = 8'h33; d[0] = 8'h00;
        tick();
        n_chk++;
        if (out_src !== 2'd3) begin n_fail++; $display("FAIL wrap_first: got %0d want 3", out_src); end
        tick();
        n_chk++;
        if (out_src !== 2'd0) begin n_fail++; $display("FAIL wrap_second: got %0d want 0", out_src); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1; in_valid = 4'b0100; in_last = 4'b0000; d[2] = 8'h77;
        tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got v=%b busy=%b want 0 0", out_valid, busy); end
        @(negedge clk);
        rst_n = 1; in_valid = 4'b0101; in_last = 4'b0101;
        #1;
        n_chk++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_restart: got %b want 0001", in_ready); end
        tick();
        n_chk++;
        if (out_src !== 2'd0) begin n_fail++; $display("FAIL rst_grant: got %0d want 0", out_src); end
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid = 4'($urandom);
            in_last = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            out_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            #1;
            er = m_ready();
            n_chk++;
            if (in_ready !== er) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", c, in_ready, er); end
            tick();
            n_chk++;
            if (dut_out !== m_out()) begin n_fail++; $display("FAIL rand_out@%0d: got %h want %h", c, dut_out, m_out()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
